// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the iterative shifter.
// Master drives requests and accepts results; slave is the shifter.
interface shift_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid,
    output in_op,
    output in_data,
    output in_amt,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_data,
    input  in_amt,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: one 1-bit shift per clock, valid/ready on both sides.
// Amounts above WIDTH saturate, so results match the full-width shift.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic               clk,
  input logic               rst,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_SLA = 2'b11;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [1:0]       op;
  logic [AMT_W-1:0] count;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  logic [AMT_W-1:0] amt_sat;
  logic [WIDTH-1:0] data_nxt;

  function automatic logic [WIDTH-1:0] shift1(
    input logic [1:0]       f,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (1'b1)
      (f == OP_SRL): r = {1'b0, d[WIDTH-1:1]};
      (f == OP_SRA): r = {d[WIDTH-1], d[WIDTH-1:1]};
      (f == OP_SLL),
      (f == OP_SLA): r = {d[WIDTH-2:0], 1'b0};
      default:       r = d;
    endcase
    return r;
  endfunction

  assign amt_sat  = (bus.in_amt > AMT_MAX) ? AMT_MAX : bus.in_amt;
  assign data_nxt = shift1(op, data);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      op        <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data  <= bus.in_data;
            op    <= bus.in_op;
            count <= amt_sat;
            busy  <= 1'b1;
            if (amt_sat == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= bus.in_data;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          data  <= data_nxt;
          count <= count - 1'b1;
          if (count == AMT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= data_nxt;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: results, latency, backpressure, reset.
// Expected values are hand-computed constants.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int AMT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE.
  task automatic req(
    input string            tag,
    input logic [1:0]       op,
    input logic [WIDTH-1:0] data,
    input logic [AMT_W-1:0] amt,
    input logic [WIDTH-1:0] exp,
    input int               lat,
    input int               hold
  );
    int   edges;
    logic bz;
    logic stable;
    logic done;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = data;
    bus.in_amt   = amt;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = ~op;
    bus.in_data  = ~data;
    bus.in_amt   = '1;
    edges = 1;
    bz    = 1'b1;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.out_valid || edges > WIDTH + 3) begin
        done = 1'b1;
      end else begin
        if (!bus.busy) bz = 1'b0;
        @(posedge clk);
        edges++;
      end
    end
    chk({tag, "_latency"}, 32'(edges), 32'(lat));
    chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
    chk({tag, "_busy"}, 32'(bz && bus.busy), 32'd1);
    if (hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        if (i == 1) begin
          bus.in_valid = 1'b1;
          bus.in_op    = 2'b01;
          bus.in_data  = 8'h55;
          bus.in_amt   = '0;
        end else begin
          bus.in_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (!bus.out_valid || bus.out_data !== exp ||
            bus.in_ready || !bus.busy)
          stable = 1'b0;
      end
      bus.in_valid = 1'b0;
      chk({tag, "_hold_stable"}, 32'(stable), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);

    req("srl3",   2'b00, 8'hB4, 4'd3,  8'h16, 4, 0);
    req("sra3",   2'b10, 8'hB4, 4'd3,  8'hF6, 4, 0);
    req("sra2",   2'b10, 8'h50, 4'd2,  8'h14, 3, 0);
    req("sll2",   2'b01, 8'h03, 4'd2,  8'h0C, 3, 0);
    req("sla2",   2'b11, 8'h03, 4'd2,  8'h0C, 3, 0);
    req("sll1",   2'b01, 8'hFF, 4'd1,  8'hFE, 2, 0);
    req("srl0",   2'b00, 8'hA5, 4'd0,  8'hA5, 1, 0);
    req("sra0",   2'b10, 8'hA5, 4'd0,  8'hA5, 1, 0);
    req("srl12",  2'b00, 8'h80, 4'd12, 8'h00, 9, 0);
    req("sra12",  2'b10, 8'h80, 4'd12, 8'hFF, 9, 0);
    req("sll8",   2'b01, 8'h01, 4'd8,  8'h00, 9, 0);
    req("sra15",  2'b10, 8'h7F, 4'd15, 8'h00, 9, 0);
    req("sra7",   2'b10, 8'h81, 4'd7,  8'hFF, 8, 0);
    req("bp_srl", 2'b00, 8'h81, 4'd1,  8'h40, 2, 5);
    req("b2b_sll", 2'b01, 8'h81, 4'd7, 8'h80, 8, 0);

    // Abort an SRA by 5 after its second shift step.
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b10;
    bus.in_data  = 8'h90;
    bus.in_amt   = 4'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_out_data", 32'(bus.out_data), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_stale", 32'(seen), 32'd0);
    req("after_abort", 2'b10, 8'h90, 4'd5, 8'hFC, 6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Iterative shift controller that sequences a single 1-bit shift stage to perform logical/arithmetic left/right shifts by a variable amount.
- Accepts one request per transaction over a valid/ready input handshake, shifts one bit per clock, and presents the result over a valid/ready output handshake.
- Acts as the area-cheap, multi-cycle alternative to the combinational shift operators in the shift datapath.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- AMT_W, 4, shift-amount field width in bits; must satisfy 2**AMT_W > WIDTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_op  input  2  operation: 00 SRL (>>), 01 SLL (<<), 10 SRA (>>>, sign fill), 11 SLA (<<<, zero fill, same as SLL).
- in_data  input  WIDTH  operand, treated as two's complement for SRA.
- in_amt  input  AMT_W  unsigned shift amount.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset: rst is sampled only on the clk rising edge and has priority over all other inputs. It forces state IDLE, out_valid=0, out_data=0, internal data/op/count registers to 0, and busy=0. While rst=1, in_ready=0.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) && !rst. The request is accepted on an edge where in_valid && in_ready.
- On accept:
  - Latch in_data into the working register and latch in_op.
  - count = min(in_amt, WIDTH), i.e. saturate at WIDTH.
  - If count==0, go to DONE; otherwise go to SHIFT.
- SHIFT, each edge:
  - Apply one 1-bit shift to the working register:
    - SRL: insert 0 at MSB.
    - SLL/SLA: insert 0 at LSB.
    - SRA: replicate the current MSB.
  - Decrement count. When the pre-decrement count==1, the next state is DONE.
- DONE:
  - out_valid=1 and out_data = working register.
  - out_data is held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1, go to IDLE and clear out_valid. out_data keeps its value but is don't-care.
- Latency: out_valid rises n_eff+1 edges after the accepting edge, where n_eff = min(in_amt, WIDTH).
  - Minimum latency is 1 (amount 0).
  - Maximum latency is WIDTH+1.
- Throughput: one request per n_eff+2 cycles at best. No accept occurs in the same cycle as the output handshake; IDLE is always visited.
- Amount >= WIDTH:
  - SRL/SLL/SLA give 0.
  - SRA gives all copies of the original sign bit.
- in_valid while not in IDLE is ignored and does not affect the transaction in flight. Inputs are don't-care except on the accepting edge.
- Changes to in_op/in_data/in_amt after accept have no effect.
- Reset mid-SHIFT or mid-DONE aborts the transaction. No out_valid is produced for it, and the block is in IDLE with in_ready=1 on the first cycle after rst drops.
- X/Z on in_data propagate bitwise through the shifts, with no special handling. X on in_valid/in_amt is illegal.

Test Plan:
- SRL, in_data=8'b1011_0100, in_amt=3 -> out_data=8'b0001_0110; out_valid asserts exactly 4 edges after accept; busy high throughout.
- SRA, in_data=8'b1011_0100, in_amt=3 -> 8'b1111_0110. SRA, in_data=8'b0101_0000, in_amt=2 -> 8'b0001_0100.
- SLL and SLA, in_data=8'b0000_0011, in_amt=2 -> both give 8'b0000_1100 after 3 edges. SLL, 8'hFF by 1 -> 8'hFE.
- Amount 0, in_data=8'hA5, any op -> out_data=8'hA5 one edge after accept. Amount 12: SRL 8'h80 -> 8'h00 and SRA 8'h80 -> 8'hFF, each after 9 edges (saturated at 8).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, pulsed in_valid ignored. out_ready=1 -> next cycle IDLE with in_ready=1, and a back-to-back second request completes correctly.
- Reset: assert rst for 1 cycle at shift step 2 of an SRA by 5 -> next cycle state IDLE, out_valid=0, out_data=0, in_ready=1, and no stale result appears afterward.
